// File: rtl/uart_pkg.sv
// Shared UART definitions: speed codes, bit periods, FSM encoding and the
// speed-code-to-period lookup used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned CNT_W       = 13;
  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [1:0] SPD_9600   = 2'b00;
  localparam logic [1:0] SPD_19200  = 2'b01;
  localparam logic [1:0] SPD_57600  = 2'b11;
  localparam logic [1:0] SPD_115200 = 2'b10;

  localparam logic [CNT_W-1:0] BIT_9600   = 13'd5208;
  localparam logic [CNT_W-1:0] BIT_19200  = 13'd2604;
  localparam logic [CNT_W-1:0] BIT_57600  = 13'd868;
  localparam logic [CNT_W-1:0] BIT_115200 = 13'd434;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

  function automatic logic [CNT_W-1:0] bit_period(input logic [1:0] spd);
    logic [CNT_W-1:0] p;
    p = BIT_9600;
    case (spd)
      SPD_9600:   p = BIT_9600;
      SPD_19200:  p = BIT_19200;
      SPD_57600:  p = BIT_57600;
      SPD_115200: p = BIT_115200;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Configuration and receive-result signals between the UART receiver and the
// register logic; master drives the rate handshake, slave returns bytes.
interface uart_rx_sampler_if;
  logic       pulse;
  logic [1:0] speed;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output pulse, speed,
    input  data_out, data_valid, frame_err, busy
  );

  modport slave (
    input  pulse, speed,
    output data_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_baud_timer.sv
// Bit-period timer: holds the requested speed, applies it only when the owner
// reports idle, and runs a free cycle counter with half/full period ticks.
module uart_baud_timer
  import uart_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst,
  input  logic       pulse,
  input  logic [1:0] speed,
  input  logic       apply_ok,
  input  logic       cnt_clr,
  output logic       half_tick,
  output logic       full_tick
);

  logic [1:0]       speed_cache_q, speed_cache_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A pulse arriving in the same cycle as an apply re-arms pending with the
  // newer code, so the last request always wins.
  always_comb begin
    speed_cache_d = speed_cache_q;
    pending_d     = pending_q;
    period_d      = period_q;
    if (apply_ok && pending_q) begin
      period_d  = bit_period(speed_cache_q);
      pending_d = 1'b0;
    end
    if (pulse) begin
      speed_cache_d = speed;
      pending_d     = 1'b1;
    end
  end

  assign half_tick = (cnt_q == (period_q >> 1) - CNT_W'(1));
  assign full_tick = (cnt_q == period_q - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_clr || full_tick) cnt_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      speed_cache_q <= SPD_9600;
      pending_q     <= 1'b0;
      period_q      <= BIT_9600;
      cnt_q         <= '0;
    end else begin
      speed_cache_q <= speed_cache_d;
      pending_q     <= pending_d;
      period_q      <= period_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: synchronizes rx, detects the start edge, samples each
// bit at mid-period and reports completed bytes or framing errors.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 rx,
  uart_rx_sampler_if.slave     bus
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs, rxs_prev_q, rxs_prev_d, fall;
  uart_state_t            state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic                   half_tick, full_tick, cnt_clr;

  assign sync_d     = {sync_q[SYNC_STAGES-2:0], rx};
  assign rxs        = sync_q[SYNC_STAGES-1];
  assign rxs_prev_d = rxs;
  assign fall       = rxs_prev_q && !rxs;

  uart_baud_timer u_timer (
    .clk_in    (clk_in),
    .rst       (rst),
    .pulse     (bus.pulse),
    .speed     (bus.speed),
    .apply_ok  (state_q == ST_IDLE),
    .cnt_clr   (cnt_clr),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q       <= '1;
      rxs_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rxs_prev_q   <= rxs_prev_d;
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (fall)      state_d = ST_START;
      ST_START:     if (half_tick) state_d = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:      if (full_tick && bit_idx_q == 3'd7) state_d = ST_STOP;
      ST_STOP:      if (full_tick) state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rxs)       state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // Counter is held at zero in IDLE and re-zeroed at the start-bit midpoint so
  // every later full tick lands in the middle of a bit.
  always_comb begin
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    cnt_clr      = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: cnt_clr = 1'b1;
      ST_START: begin
        if (half_tick) begin
          cnt_clr   = 1'b1;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (full_tick) begin
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        if (full_tick) begin
          if (rxs) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Serial receiver for the 8N1 UART link. It is the receive-side counterpart of the baud clock divider and uses the same 2-bit speed code and the same `pulse` reconfiguration handshake.
- Counts clk_in cycles directly instead of using a divided clock. Finds the start bit, samples each bit at mid-period and delivers one byte per frame to the Nios-facing register logic.
- Reports framing errors and a busy status.

Parameters:
- BIT_9600, 5208, clk_in cycles per bit, speed code 2'b00
- BIT_19200, 2604, clk_in cycles per bit, speed code 2'b01
- BIT_57600, 868, clk_in cycles per bit, speed code 2'b11
- BIT_115200, 434, clk_in cycles per bit, speed code 2'b10
- SYNC_STAGES, 2, flip-flop stages on rx before any use

Ports:
- clk_in  input  1  system clock (50 MHz)
- rst  input  1  reset, synchronous, active-high
- rx  input  1  asynchronous serial line, idle high
- pulse  input  1  single-cycle strobe: load `speed` as the new rate
- speed  input  2  rate code, sampled only on `pulse`
- data_out  output  8  last correctly framed byte
- data_valid  output  1  one-cycle strobe when data_out updates
- frame_err  output  1  one-cycle strobe when the stop bit is sampled low
- busy  output  1  high from start detect until return to IDLE

Behaviour:
- Reset values:
  - data_out=0, data_valid=0, frame_err=0, busy=0.
  - State=IDLE, bit period=BIT_9600.
  - Synchronizer flops=1; pending-config flag=0.
- rx passes through SYNC_STAGES flops; all logic uses the synchronized value rxs. The counter is 13 bits wide.
- Reconfiguration:
  - `pulse` latches `speed` into speed_cache and sets the pending flag.
  - The pending flag is applied when the FSM is in IDLE. The bit period updates on the next cycle and the flag clears.
  - A pulse while busy takes effect only after the current frame finishes; the frame in progress keeps its old rate.
  - A second pulse before the pending flag is applied overwrites speed_cache; the last one wins.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - A high-to-low transition on rxs moves to START, loads counter=0 and sets busy.
  - A start edge and a pending config in the same cycle: the config is applied first, then the frame is received at the new rate.
- START:
  - At counter = half bit period − 1, sample rxs.
  - rxs high means a glitch: return to IDLE, busy=0, no strobes.
  - rxs low: go to DATA with counter=0 and bit index=0.
- DATA:
  - Every full bit period, sample rxs into the shift register, LSB first.
  - After bit index 7, go to STOP.
- STOP (one full period later):
  - rxs=1: data_out ← shift register, data_valid=1 for one cycle, go to IDLE, busy=0.
  - rxs=0: frame_err=1 for one cycle, data_out unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs=1, then go to IDLE and clear busy. This covers a break condition.
- Latency from the start edge at rxs (cycle T), with B = bit period:
  - Start sample at T+B/2.
  - Data bit k sampled at T+B/2+B·(k+1).
  - Stop sample at T+B/2+9B.
  - Strobe at stop sample +1.
- data_valid and frame_err are never asserted in the same cycle. Both are registered outputs.
- rst asserted mid-frame aborts the frame immediately. No strobe is issued, and the rate returns to BIT_9600.

Decomposition:
- Shared package `uart_pkg`:
  - Speed code constants SPD_9600=2'b00, SPD_19200=2'b01, SPD_57600=2'b11, SPD_115200=2'b10.
  - Bit-period constants.
  - FSM state encoding, also used by the future uart_tx.
- One natural sub-module, `uart_baud_timer`. It holds speed_cache, the pending flag, the bit-period select and the 13-bit counter. It outputs half_tick and full_tick and is reused by the transmitter.

Test Plan:
- Reset, then rx=1 for 10000 cycles → busy=0, data_valid never set, data_out=0x00.
- Default rate, send frame 0xA5 (5208 cycles/bit) → data_valid pulses once, exactly 5208/2+9·5208+1 cycles after the synced start edge, data_out=0xA5, frame_err=0.
- pulse with speed=2'b10 in IDLE, then send 0x3C then 0xFF back-to-back at 434 cycles/bit → two data_valid pulses, data_out=0x3C then 0xFF, no frame_err.
- Send 0x55 at 115200 with the stop bit forced low, then line high after 2 bit times → frame_err pulses once, data_out retains its previous value, busy stays high until rx returns high.
- Low glitch on rx of 100 cycles at 9600 → no state beyond START, busy drops at the half-bit check, no strobes.
- pulse speed=2'b01 mid-frame at 9600 → the current byte is received correctly at 9600; the next frame at 2604 cycles/bit is received correctly. Also assert rst mid-frame → no strobe, rate reverts to 9600.
